store_fwd_ctrl: RTL and testbench
=================================

Name: store_fwd_ctrl

Overview:
- Controller that sequences the store-data source select (dm_src) for the data-memory write multiplexer in the 5-stage pipeline.
- Tracks destination registers of the two instructions ahead of a store (EX and MEM slots).
- Chooses between register-file data, a one-ahead forwarded result and a two-ahead forwarded result.
- Raises a one-cycle load-use stall when the needed value is not yet available.

Parameters:
- REG_W, 5, register index width
- ZERO_REG, 0, index of hard-wired zero register; never forwarded or stalled on

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID-stage instruction valid
- id_rs1  in  REG_W  ID source 1 (address base)
- id_rs2  in  REG_W  ID source 2 (store data)
- id_use_rs1  in  1  ID instruction reads rs1
- id_is_store  in  1  ID instruction is a store
- id_rd  in  REG_W  ID destination
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- flush  in  1  branch/jump flush of ID and EX
- stall  out  1  hold PC and IF/ID, bubble into EX
- dm_src  out  2  store-data select, aligned to store in MEM: 00 busB, 01 Result, 10 mem_result
- ex_dm_src  out  2  pending select of instruction in EX (debug/observe)

Behaviour:
- Reset (async, rst_n=0): stall=0, dm_src=00, ex_dm_src=00, all tracking slots invalid, FSM=RUN. Deassertion is sampled on the next clk rising edge.
- Tracking slots, updated every rising edge:
  - EX slot {v, rd, regwrite, memread}
  - MEM slot {v, rd, regwrite}
  - MEM slot <= EX slot each edge.
  - EX slot <= ID fields with v=id_valid, except v=0 when stall=1 or flush=1.
- Hazard match: a slot "hits" register r when v=1, regwrite=1, rd==r and r!=ZERO_REG.
- Load-use stall (combinational):
  - stall = id_valid & ~flush & FSM==RUN & EX hits and EX.memread.
  - Applies if (id_use_rs1 and hit on id_rs1) or (id_is_store and hit on id_rs2).
- Select decision for an ID store with no stall, priority order:
  - EX hits id_rs2 (non-load) -> 01
  - else MEM hits id_rs2 -> 10
  - else 00
- Non-store or invalid ID -> 00.
- Latency:
  - decision registered into ex_dm_src at edge after ID
  - copied to dm_src at following edge
  - total 2 cycles from ID to dm_src.
  - During stall or flush: ex_dm_src <= 00.
- FSM:
  - RUN -> STALL when stall=1.
  - STALL -> RUN unconditionally next cycle.
  - In STALL, stall is forced 0. The load has moved to MEM, so a store-data dependency resolves as 10.
  - Exactly one stall cycle per load-use.
- Simultaneous flush and hazard: flush wins; stall=0, EX bubble, FSM stays/returns RUN.
- EX and MEM both hit id_rs2: EX (younger) wins -> 01.
- Store in ID whose rs2 equals the store's own rd: irrelevant, since stores have regwrite=0.
- Reset mid-stall: all state cleared immediately; stall drops asynchronously.

Optional Feature:
- Macro STORE_FWD_STATS_EN.
- When defined, adds 32-bit outputs fwd1_cnt, fwd2_cnt, stall_cnt. Each counts cycles where ex_dm_src is loaded with 01, is loaded with 10, or stall=1, respectively.
- Counters wrap at 2^32-1 -> 0 and are reset to 0 by rst_n.
- When not defined, the counters and ports are absent; all other behaviour is identical.

Test Plan:
- Reset held, then released with no instructions -> stall=0, dm_src=00 for 10 cycles.
- ADD rd=5 then SW rs2=5 back-to-back -> no stall; ex_dm_src=01 one cycle after SW in ID, dm_src=01 next cycle, then 00.
- ADD rd=7, NOP, SW rs2=7 -> dm_src=10 two cycles after SW in ID; ADD rd=0, SW rs2=0 -> dm_src=00.
- LW rd=3 then SW rs2=3 -> stall=1 exactly one cycle, EX bubble, then dm_src=10 for the SW; LW rd=3 then ADD rs1=3 -> one stall, dm_src stays 00.
- LW rd=4 with SW rs2=4 in ID and flush=1 same cycle -> stall=0, ex_dm_src=00, FSM RUN; also ADD rd=6, ADD rd=6, SW rs2=6 -> 01 (EX priority).
- rst_n pulsed low during STALL cycle -> stall=0 and dm_src=00 immediately, slots invalid; with STORE_FWD_STATS_EN, counters read 0 afterwards and increment 1 per matching event.

Source files
------------

// File: rtl/store_fwd_ctrl.sv
// rtl/store_fwd_ctrl.sv - store-data forwarding select and load-use stall controller
// Optional STORE_FWD_STATS_EN adds forwarding/stall event counters.
module store_fwd_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_is_store,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
`ifdef STORE_FWD_STATS_EN
  output logic [31:0]      fwd1_cnt,
  output logic [31:0]      fwd2_cnt,
  output logic [31:0]      stall_cnt,
`endif
  output logic             stall,
  output logic [1:0]       dm_src,
  output logic [1:0]       ex_dm_src
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  typedef enum logic {S_RUN, S_STALL} state_e;

  state_e           state_q, state_d;
  logic             ex_v_q, ex_v_d, ex_rw_q, ex_rw_d, ex_mr_q, ex_mr_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic             mem_v_q, mem_v_d, mem_rw_q, mem_rw_d;
  logic [1:0]       ex_sel_q, ex_sel_d, dm_sel_q, dm_sel_d;

  logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs2;

  always_comb begin
    ex_hit_rs1  = ex_v_q & ex_rw_q & (ex_rd_q == id_rs1) & (id_rs1 != ZR);
    ex_hit_rs2  = ex_v_q & ex_rw_q & (ex_rd_q == id_rs2) & (id_rs2 != ZR);
    mem_hit_rs2 = mem_v_q & mem_rw_q & (mem_rd_q == id_rs2) & (id_rs2 != ZR);

    // In S_STALL the load has already advanced to MEM, so no second stall.
    stall = id_valid & ~flush & (state_q == S_RUN) & ex_mr_q &
            ((id_use_rs1 & ex_hit_rs1) | (id_is_store & ex_hit_rs2));

    state_d = S_RUN;
    if (state_q == S_RUN && stall)
      state_d = S_STALL;

    ex_sel_d = 2'b00;
    if (id_valid && id_is_store && !stall && !flush) begin
      if (ex_hit_rs2 && !ex_mr_q)
        ex_sel_d = 2'b01;
      else if (mem_hit_rs2)
        ex_sel_d = 2'b10;
    end
    dm_sel_d = ex_sel_q;

    ex_v_d   = id_valid & ~stall & ~flush;
    ex_rd_d  = id_rd;
    ex_rw_d  = id_regwrite;
    ex_mr_d  = id_memread;
    mem_v_d  = ex_v_q;
    mem_rd_d = ex_rd_q;
    mem_rw_d = ex_rw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      ex_v_q   <= 1'b0;
      ex_rd_q  <= '0;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_rw_q <= 1'b0;
      ex_sel_q <= 2'b00;
      dm_sel_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= ex_rd_d;
      ex_rw_q  <= ex_rw_d;
      ex_mr_q  <= ex_mr_d;
      mem_v_q  <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      mem_rw_q <= mem_rw_d;
      ex_sel_q <= ex_sel_d;
      dm_sel_q <= dm_sel_d;
    end
  end

  assign ex_dm_src = ex_sel_q;
  assign dm_src    = dm_sel_q;

`ifdef STORE_FWD_STATS_EN
  logic [31:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d, stc_q, stc_d;

  always_comb begin
    fwd1_d = fwd1_q + ((ex_sel_d == 2'b01) ? 32'd1 : 32'd0);
    fwd2_d = fwd2_q + ((ex_sel_d == 2'b10) ? 32'd1 : 32'd0);
    stc_d  = stc_q + (stall ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd1_q <= '0;
      fwd2_q <= '0;
      stc_q  <= '0;
    end else begin
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
      stc_q  <= stc_d;
    end
  end

  assign fwd1_cnt  = fwd1_q;
  assign fwd2_cnt  = fwd2_q;
  assign stall_cnt = stc_q;
`endif

endmodule

// File: tb/tb_store_fwd_ctrl.sv
// tb/tb_store_fwd_ctrl.sv - randomized check of store_fwd_ctrl against a pipeline reference model
module tb_store_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_is_store, id_regwrite, id_memread, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall;
  logic [1:0] dm_src, ex_dm_src;
`ifdef STORE_FWD_STATS_EN
  logic [31:0] fwd1_cnt, fwd2_cnt, stall_cnt;
  int unsigned m_f1, m_f2, m_st;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  store_fwd_ctrl #(.REG_W(5), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_is_store(id_is_store), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
`ifdef STORE_FWD_STATS_EN
    .fwd1_cnt(fwd1_cnt), .fwd2_cnt(fwd2_cnt), .stall_cnt(stall_cnt),
`endif
    .stall(stall), .dm_src(dm_src), .ex_dm_src(ex_dm_src)
  );

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
    bit [1:0] sel;
  } instr_t;

  // Index 0 = instruction now in EX, 1 = instruction now in MEM.
  instr_t pipe [2];
  bit     m_in_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(instr_t e, bit [4:0] r);
    return e.v && e.rw && e.rd == r && r != 5'd0;
  endfunction

  function automatic bit exp_stall();
    if (!id_valid || flush || m_in_stall || !pipe[0].mr) return 1'b0;
    return (id_use_rs1 && writes(pipe[0], id_rs1)) || (id_is_store && writes(pipe[0], id_rs2));
  endfunction

  function automatic bit [1:0] exp_sel(bit st);
    if (!id_valid || !id_is_store || st || flush) return 2'b00;
    if (writes(pipe[0], id_rs2) && !pipe[0].mr) return 2'b01;
    if (writes(pipe[1], id_rs2)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) pipe[i] = '{v: 0, rd: 0, rw: 0, mr: 0, sel: 0};
    m_in_stall = 0;
`ifdef STORE_FWD_STATS_EN
    m_f1 = 0; m_f2 = 0; m_st = 0;
`endif
  endtask

  task automatic model_step(bit st);
    instr_t n;
    n.v   = id_valid && !st && !flush;
    n.rd  = id_rd;
    n.rw  = id_regwrite;
    n.mr  = id_memread;
    n.sel = exp_sel(st);
`ifdef STORE_FWD_STATS_EN
    if (n.sel == 2'b01) m_f1++;
    if (n.sel == 2'b10) m_f2++;
    if (st) m_st++;
`endif
    pipe[1]    = pipe[0];
    pipe[0]    = n;
    m_in_stall = st;
  endtask

  task automatic drive_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_is_store = 0;
    id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0;
  endtask

  // Small register range so that dependencies are frequent.
  task automatic drive_random();
    int op;
    op          = $urandom_range(0, 4);
    id_valid    = (op != 0);
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    id_rd       = 5'($urandom_range(0, 3));
    id_use_rs1  = ($urandom_range(0, 3) != 0);
    id_is_store = (op == 3 || op == 4);
    id_regwrite = (op == 1 || op == 2);
    id_memread  = (op == 2);
    flush       = ($urandom_range(0, 11) == 0);
  endtask

  task automatic check_outputs(output bit st);
    st = exp_stall();
    chk("stall", {31'd0, stall}, {31'd0, st});
    chk("ex_dm_src", {30'd0, ex_dm_src}, {30'd0, pipe[0].sel});
    chk("dm_src", {30'd0, dm_src}, {30'd0, pipe[1].sel});
`ifdef STORE_FWD_STATS_EN
    chk("fwd1_cnt", fwd1_cnt, m_f1);
    chk("fwd2_cnt", fwd2_cnt, m_f2);
    chk("stall_cnt", stall_cnt, m_st);
`endif
  endtask

  initial begin
    bit st;
    bit got_stall;
    int budget;
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_outputs(st);
      @(posedge clk);
      model_step(st);
      #1;
    end

    for (int c = 0; c < 3000; c++) begin
      // A stalled ID instruction is held in place, as IF/ID would be.
      if (!m_in_stall || c == 0) drive_random();
      @(negedge clk);
      check_outputs(st);
      @(posedge clk);
      model_step(st);
      #1;
      if (st) begin
        @(negedge clk);
        check_outputs(st);
        @(posedge clk);
        model_step(st);
        #1;
      end
    end

    // Reset asserted while the controller is in its stall cycle.
    got_stall = 0;
    budget = 0;
    while (!got_stall && budget < 2000) begin
      budget++;
      drive_random();
      @(negedge clk);
      check_outputs(st);
      @(posedge clk);
      model_step(st);
      #1;
      got_stall = st;
    end
    chk("stall_reached", {31'd0, got_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dm_src", {30'd0, dm_src}, 32'd0);
    chk("rst_ex_dm_src", {30'd0, ex_dm_src}, 32'd0);
`ifdef STORE_FWD_STATS_EN
    chk("rst_fwd1", fwd1_cnt, 32'd0);
    chk("rst_fwd2", fwd2_cnt, 32'd0);
    chk("rst_stallc", stall_cnt, 32'd0);
`endif
    drive_idle();
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 400; c++) begin
      if (!m_in_stall) drive_random();
      @(negedge clk);
      check_outputs(st);
      @(posedge clk);
      model_step(st);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
